retire_check_sync: RTL and testbench
====================================

Name: retire_check_sync

Overview:
- Producer side of the two-model lock-step check. Sits inside the processor next to the writeback stage.
- Captures each retired instruction's PC, plus the address and data for stores, into a small FIFO.
- Presents one check event at a time to the checker, which drives the behavioral model, using a valid/ready handshake.
- Asserts a stall request to the pipeline before the FIFO can overflow, so no retirement is ever lost.

Parameters:
- ADDR_W, 32, width of the store address (normally tied to MEM_ADDR_WIDTH).
- DEPTH, 4, number of FIFO entries; must be a power of two and at least 2.
- SEQ_W, 16, width of the retirement sequence counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ret_valid  in  1  an instruction retires this cycle.
- ret_pc  in  32  PC of the retiring instruction.
- ret_store  in  1  the retiring instruction is SB, SH or SW.
- ret_addr  in  ADDR_W  store effective address; ignored when ret_store=0.
- ret_data  in  32  store data aligned to the bus lanes.
- ret_be  in  4  store byte enables; bit i covers data[8i+7:8i].
- chk_ready  in  1  checker consumes the presented event at this edge.
- check_en  out  1  a check event is presented.
- check_pc  out  32  PC of the presented event.
- check_store  out  1  the presented event is a store.
- check_addr  out  ADDR_W  store address of the presented event.
- check_data  out  32  store data with disabled byte lanes forced to 0.
- check_seq  out  SEQ_W  retirement sequence number of the presented event.
- stall_req  out  1  pipeline must not retire in the next cycle.
- overflow  out  1  sticky flag: a retirement was dropped.

Behaviour:
- Reset (rst=0, asynchronous): write and read pointers, count and sequence counter go to 0, and overflow is cleared.
- Reset values of outputs: check_en=0, stall_req=0, overflow=0, and check_pc, check_store, check_addr, check_data and check_seq all read 0.
- Reset mid-operation discards every buffered event and restarts the sequence numbering at 0.
- Push: occurs at an edge where ret_valid=1 and (count<DEPTH, or a pop happens at the same edge).
  - The entry stored is {ret_pc, ret_store, ret_addr, ret_data masked by ret_be, seq}.
  - When ret_store=0, the address and data fields are stored as 0.
  - seq increments by 1 on every accepted push and wraps from 2^SEQ_W-1 to 0.
- Pop: occurs at an edge where check_en=1 and chk_ready=1; the read pointer advances.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count runs from 0 to DEPTH.
- Presentation:
  - check_en equals (count!=0). The check_* outputs are driven from the head entry, and all of them are functions of registered state only.
  - Latency: with the FIFO empty and ret_valid sampled at edge N, check_en is high after edge N.
  - The head entry and check_en stay stable until a pop occurs.
  - When check_en=0, the check_* data outputs read 0.
- Simultaneous push and pop: count is unchanged, and this is allowed even when the FIFO is full.
- Simultaneous push and pop with count=0 is impossible, because check_en=0 means no pop.
- stall_req equals (count >= DEPTH-1), computed combinationally from the count register.
- Full with a push and no pop: the event is dropped, overflow is set and stays set until reset, and seq does not increment.
- Data masking: byte lane i of the stored data is 0 whenever ret_be[i]=0.
- chk_ready asserted while check_en=0 has no effect.

Test Plan:
1. Reset then single event: release rst, then ret_valid=1 with ret_pc=0xBFC00000 and ret_store=0, with chk_ready=1. Required: check_en is high for exactly one cycle after that edge, check_pc=0xBFC00000, check_seq=0, check_store=0, check_data=0.
2. Store masking: ret_store=1, ret_addr=0x00000104, ret_data=0xAABBCCDD, ret_be=4'b0010. Required: check_addr=0x104, check_data=0x0000CC00, check_store=1.
3. Backpressure and stall: hold chk_ready=0 and retire 3 events with DEPTH=4. Required: stall_req goes high after the 3rd push. After a 4th push the FIFO is full and overflow=0. Then raising chk_ready drains the events in order with seq 0,1,2,3.
4. Overflow: with the FIFO full and chk_ready=0, a 5th ret_valid is dropped. Required: overflow=1, and later presented seq values skip nothing (4 is the next seq).
5. Full with simultaneous push and pop: count=4, chk_ready=1 and ret_valid=1 at the same edge. Required: count stays 4, overflow stays 0, and the new entry appears 4 pops later.
6. Wrap and async reset: retire 65537 events with chk_ready=1. Required: check_seq wraps 0xFFFF→0x0000. Dropping rst mid-burst immediately forces check_en=0, and the next event after release presents seq 0.

Source files
------------

// File: rtl/retire_check_sync.sv
// Retirement capture FIFO feeding the lock-step checker.
// Buffers retired PCs and store effects, hands them out one per handshake.
module retire_check_sync #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  parameter int SEQ_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ret_valid,
  input  logic [31:0]       ret_pc,
  input  logic              ret_store,
  input  logic [ADDR_W-1:0] ret_addr,
  input  logic [31:0]       ret_data,
  input  logic [3:0]        ret_be,
  input  logic              chk_ready,
  output logic              check_en,
  output logic [31:0]       check_pc,
  output logic              check_store,
  output logic [ADDR_W-1:0] check_addr,
  output logic [31:0]       check_data,
  output logic [SEQ_W-1:0]  check_seq,
  output logic              stall_req,
  output logic              overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] HIGH = CW'(DEPTH - 1);

  typedef struct packed {
    logic [31:0]       pc;
    logic              store;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [SEQ_W-1:0]  seq;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            entry_d;
  entry_t            head;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic              ovf_q, ovf_d;
  logic              push, pop;
  logic [31:0]       masked;

  always_comb begin
    masked = '0;
    for (int i = 0; i < 4; i++) begin
      masked[8*i +: 8] = ret_be[i] ? ret_data[8*i +: 8] : 8'h00;
    end
  end

  assign pop  = (count_q != '0) && chk_ready;
  assign push = ret_valid && ((count_q < FULL) || pop);

  always_comb begin
    entry_d       = '0;
    entry_d.pc    = ret_pc;
    entry_d.store = ret_store;
    entry_d.seq   = seq_q;
    if (ret_store) begin
      entry_d.addr = ret_addr;
      entry_d.data = masked;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    seq_d    = seq_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      seq_d    = seq_q + SEQ_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Full, nothing leaving: the retirement is lost for good
    if (ret_valid && !push) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      seq_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      seq_q    <= seq_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= entry_d;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign check_en  = (count_q != '0);
  assign stall_req = (count_q >= HIGH);
  assign overflow  = ovf_q;

  always_comb begin
    check_pc    = '0;
    check_store = 1'b0;
    check_addr  = '0;
    check_data  = '0;
    check_seq   = '0;
    if (check_en) begin
      check_pc    = head.pc;
      check_store = head.store;
      check_addr  = head.addr;
      check_data  = head.data;
      check_seq   = head.seq;
    end
  end

endmodule

// File: tb/tb_retire_check_sync.sv
// Randomized and directed checks of retire_check_sync
// against a queue-based model of the retirement FIFO.
module tb_retire_check_sync;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ret_valid = 1'b0;
  logic [31:0] ret_pc = '0;
  logic        ret_store = 1'b0;
  logic [31:0] ret_addr = '0;
  logic [31:0] ret_data = '0;
  logic [3:0]  ret_be = '0;
  logic        chk_ready = 1'b0;
  logic        check_en;
  logic [31:0] check_pc;
  logic        check_store;
  logic [31:0] check_addr;
  logic [31:0] check_data;
  logic [15:0] check_seq;
  logic        stall_req;
  logic        overflow;

  retire_check_sync #(.ADDR_W(32), .DEPTH(DEPTH), .SEQ_W(16)) dut (
    .clk(clk), .rst(rst),
    .ret_valid(ret_valid), .ret_pc(ret_pc),
    .ret_store(ret_store), .ret_addr(ret_addr),
    .ret_data(ret_data), .ret_be(ret_be),
    .chk_ready(chk_ready),
    .check_en(check_en), .check_pc(check_pc),
    .check_store(check_store), .check_addr(check_addr),
    .check_data(check_data), .check_seq(check_seq),
    .stall_req(stall_req), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          st;
    logic [31:0] addr;
    logic [31:0] data;
    int          seq;
  } ev_t;

  ev_t q[$];
  int  mseq;
  bit  movf;
  int  checks = 0;
  int  failures = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    mseq = 0;
    movf = 0;
  endtask

  task automatic compare_all(input string tag);
    ev_t h;
    h = '{pc: 0, st: 0, addr: 0, data: 0, seq: 0};
    if (q.size() != 0) h = q[0];
    chk({tag, ".en"},    64'(check_en),    64'(q.size() != 0));
    chk({tag, ".pc"},    64'(check_pc),    64'(h.pc));
    chk({tag, ".store"}, 64'(check_store), 64'(h.st));
    chk({tag, ".addr"},  64'(check_addr),  64'(h.addr));
    chk({tag, ".data"},  64'(check_data),  64'(h.data));
    chk({tag, ".seq"},   64'(check_seq),   64'(h.seq));
    chk({tag, ".stall"}, 64'(stall_req),   64'(q.size() >= DEPTH - 1));
    chk({tag, ".ovf"},   64'(overflow),    64'(movf));
  endtask

  task automatic step(input string tag, input bit v,
                      input logic [31:0] pc, input bit st,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input bit rdy);
    bit  pop, push;
    ev_t e;
    ret_valid = v; ret_pc = pc; ret_store = st;
    ret_addr = a; ret_data = d; ret_be = be;
    chk_ready = rdy;
    @(posedge clk);
    pop  = (q.size() != 0) && rdy;
    push = v && ((q.size() < DEPTH) || pop);
    e.pc = pc;
    e.st = st;
    e.addr = st ? a : 32'h0;
    e.data = 32'h0;
    if (st) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) e.data = e.data | (d & (32'hFF << (8 * i)));
    end
    e.seq = mseq;
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(e);
      mseq = (mseq + 1) % 65536;
    end else if (v) begin
      movf = 1;
    end
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag, input bit rdy);
    step(tag, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    ret_valid = 0; chk_ready = 0; ret_store = 0;
    rst = 0;
    model_clear();
    #1;
    compare_all("reset");
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    int cnt;
    model_clear();
    do_reset();

    // 1: single event, one-cycle presentation
    step("t1a", 1, 32'hBFC00000, 0, 32'h0, 32'h0, 4'h0, 1);
    chk("t1_pc", 64'(check_pc), 64'hBFC00000);
    chk("t1_seq", 64'(check_seq), 64'h0);
    idle("t1b", 1);
    chk("t1_en_low", 64'(check_en), 64'h0);

    // 2: store masking
    do_reset();
    step("t2", 1, 32'h100, 1, 32'h104, 32'hAABBCCDD, 4'b0010, 0);
    chk("t2_addr", 64'(check_addr), 64'h104);
    chk("t2_data", 64'(check_data), 64'h0000CC00);
    chk("t2_store", 64'(check_store), 64'h1);

    // 3 and 4: backpressure, stall, overflow, in-order drain
    do_reset();
    for (int i = 0; i < 3; i++)
      step("t3p", 1, 32'h1000 + 4 * i, 0, 0, 0, 0, 0);
    chk("t3_stall", 64'(stall_req), 64'h1);
    step("t3p4", 1, 32'h100C, 0, 0, 0, 0, 0);
    chk("t3_ovf0", 64'(overflow), 64'h0);
    step("t4drop", 1, 32'h1010, 0, 0, 0, 0, 0);
    chk("t4_ovf1", 64'(overflow), 64'h1);
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain_seq", 64'(check_seq), 64'(i));
      idle("t3d", 1);
    end
    step("t4next", 1, 32'h2000, 0, 0, 0, 0, 0);
    chk("t4_seq4", 64'(check_seq), 64'h4);

    // 5: full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 4; i++)
      step("t5f", 1, 32'h3000 + 4 * i, 0, 0, 0, 0, 0);
    step("t5pp", 1, 32'h3F00, 1, 32'h44, 32'h12345678, 4'hF, 1);
    chk("t5_ovf", 64'(overflow), 64'h0);
    chk("t5_stall", 64'(stall_req), 64'h1);
    for (int i = 0; i < 3; i++) idle("t5d", 1);
    chk("t5_newpc", 64'(check_pc), 64'h3F00);
    chk("t5_newseq", 64'(check_seq), 64'h4);
    idle("t5e", 1);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++)
      step("rnd", ($urandom_range(0, 3) != 0), $urandom,
           $urandom_range(0, 1), $urandom, $urandom,
           4'($urandom), ($urandom_range(0, 2) != 0));
    for (int i = 0; i < 6; i++) idle("rnd_drain", 1);

    // 6: sequence wrap with full-rate retire
    do_reset();
    cnt = 0;
    for (int i = 0; i < 65537; i++) begin
      step("t6", 1, 32'(i * 4), 0, 0, 0, 0, 1);
      if (check_seq == 16'h0 && i > 1000) cnt++;
    end
    chk("t6_wrapped", 64'(cnt), 64'h1);
    for (int i = 0; i < 5; i++)
      step("t6b", 1, 32'h5000, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("t6_async_en", 64'(check_en), 64'h0);
    chk("t6_async_stall", 64'(stall_req), 64'h0);
    ret_valid = 0;
    model_clear();
    @(negedge clk);
    rst = 1;
    step("t6c", 1, 32'h6000, 0, 0, 0, 0, 0);
    chk("t6_seq0", 64'(check_seq), 64'h0);
    chk("t6_pc", 64'(check_pc), 64'h6000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
